// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: difference and borrow for a single bit position.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per clock, LSB first, using a single full_subtractor.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output V.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  input  logic             sa,
  input  logic             sb,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
`ifdef SERIAL_SUB_OVF_EN
  output logic             V,
`endif
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   aa_q, aa_d;
  logic [WIDTH-1:0]   bb_q, bb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               br_q, br_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bo_q, bo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic               v_q, v_d;
`endif

  logic fs_d;
  logic fs_bout;
  logic last_bit;

  // The operand registers shift right, so bit 0 is always the bit in flight.
  full_subtractor u_fs (
    .a    (aa_q[0]),
    .b    (bb_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aa_d    = aa_q;
    bb_d    = bb_q;
    res_d   = res_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    v_d     = v_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          aa_d    = A & {WIDTH{sa}};
          bb_d    = B & {WIDTH{sb}};
          br_d    = Bi;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        aa_d  = aa_q >> 1;
        bb_d  = bb_q >> 1;
        br_d  = fs_bout;
        res_d = {fs_d, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          diff_d  = {fs_d, res_q[WIDTH-1:1]};
          bo_d    = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
          // On the final bit the operand bits in flight are the original MSBs.
          v_d     = (aa_q[0] ^ bb_q[0]) & (fs_d ^ aa_q[0]);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      aa_q    <= '0;
      bb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aa_q    <= aa_d;
      bb_q    <= bb_d;
      res_q   <= res_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  assign D    = diff_q;
  assign Bo   = bo_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SERIAL_SUB_OVF_EN
  assign V    = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4); V checks when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bi;
  logic       sa;
  logic       sb;
  logic [3:0] D;
  logic       Bo;
  logic       busy;
  logic       done;
`ifdef SERIAL_SUB_OVF_EN
  logic       V;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bi    (Bi),
    .sa    (sa),
    .sb    (sb),
    .D     (D),
    .Bo    (Bo),
`ifdef SERIAL_SUB_OVF_EN
    .V     (V),
`endif
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start high across one rising edge; returns at the negedge after it.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                          input logic s_a, input logic s_b);
    @(negedge clk);
    A = a; B = b; Bi = bi; sa = s_a; sb = s_b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walk negedges until done (bounded); cyc counts cycles since the start edge.
  task automatic wait_done(output int cyc, output int nbusy);
    cyc = 1;
    nbusy = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    total_cnt++;
    if ({D, Bo, busy, done} !== 7'b0) $display("FAIL reset_outputs: got D=%0d Bo=%b busy=%b done=%b, want all 0", D, Bo, busy, done);
    else pass_cnt++;
`ifdef SERIAL_SUB_OVF_EN
    total_cnt++;
    if (V !== 1'b0) $display("FAIL reset_v: got %b want 0", V);
    else pass_cnt++;
`endif
  endtask

  task automatic test_basic;
    int cyc, nb;
    start_op(4'd9, 4'd3, 1'b0, 1'b1, 1'b1);
    wait_done(cyc, nb);
    total_cnt++;
    if (cyc !== 5) $display("FAIL basic_done_latency: got %0d want 5", cyc);
    else pass_cnt++;
    total_cnt++;
    if (nb !== 4) $display("FAIL basic_busy_cycles: got %0d want 4", nb);
    else pass_cnt++;
    total_cnt++;
    if (D !== 4'd6 || Bo !== 1'b0) $display("FAIL basic_9m3: got D=%0d Bo=%b want D=6 Bo=0", D, Bo);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL basic_busy_in_done: got %b want 0", busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL basic_done_single: got %b want 0", done);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (D !== 4'd6 || Bo !== 1'b0 || busy !== 1'b0) $display("FAIL basic_hold: got D=%0d Bo=%b busy=%b want 6 0 0", D, Bo, busy);
    else pass_cnt++;
  endtask

  task automatic test_vectors;
    logic [3:0] va [4] = '{4'd3, 4'd5, 4'd7, 4'd7};
    logic [3:0] vb [4] = '{4'd9, 4'd5, 4'd2, 4'd2};
    logic       vbi[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       vsa[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       vsb[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] ed [4] = '{4'd10, 4'd15, 4'd14, 4'd7};
    logic       ebo[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int cyc, nb;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], vbi[i], vsa[i], vsb[i]);
      wait_done(cyc, nb);
      total_cnt++;
      if (cyc !== 5 || D !== ed[i] || Bo !== ebo[i])
        $display("FAIL vector_%0d: got D=%0d Bo=%b at cycle %0d, want D=%0d Bo=%b at cycle 5", i, D, Bo, cyc, ed[i], ebo[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored;
    int ndone = 0;
    logic [3:0] dsnap = 4'hx;
    logic       bsnap = 1'bx;
    start_op(4'd9, 4'd3, 1'b0, 1'b1, 1'b1);
    start = 1'b1; A = 4'd3; B = 4'd9;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        dsnap = D;
        bsnap = Bo;
      end
      @(negedge clk);
    end
    start = 1'b0;
    total_cnt++;
    if (ndone !== 1) $display("FAIL restart_done_count: got %0d want 1", ndone);
    else pass_cnt++;
    total_cnt++;
    if (dsnap !== 4'd6 || bsnap !== 1'b0) $display("FAIL restart_result: got D=%0d Bo=%b want D=6 Bo=0", dsnap, bsnap);
    else pass_cnt++;
  endtask

  task automatic test_input_change;
    int cyc, nb;
    start_op(4'd7, 4'd2, 1'b1, 1'b1, 1'b1);
    A = 4'd0; B = 4'd15; Bi = 1'b0; sa = 1'b0;
    wait_done(cyc, nb);
    total_cnt++;
    if (cyc !== 5 || D !== 4'd4 || Bo !== 1'b0) $display("FAIL input_change: got D=%0d Bo=%b cycle %0d want D=4 Bo=0 cycle 5", D, Bo, cyc);
    else pass_cnt++;
    sa = 1'b1;
  endtask

  task automatic test_mid_reset;
    int cyc, nb;
    int seen = 0;
    start_op(4'd9, 4'd2, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({D, Bo, busy, done} !== 7'b0) $display("FAIL midreset_async: got D=%0d Bo=%b busy=%b done=%b want all 0", D, Bo, busy, done);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL midreset_no_done: got %0d active cycles want 0", seen);
    else pass_cnt++;
    start_op(4'd4, 4'd1, 1'b0, 1'b1, 1'b1);
    wait_done(cyc, nb);
    total_cnt++;
    if (cyc !== 5 || D !== 4'd3 || Bo !== 1'b0) $display("FAIL midreset_fresh: got D=%0d Bo=%b cycle %0d want D=3 Bo=0 cycle 5", D, Bo, cyc);
    else pass_cnt++;
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf;
    int cyc, nb;
    start_op(4'd8, 4'd1, 1'b0, 1'b1, 1'b1);
    wait_done(cyc, nb);
    total_cnt++;
    if (D !== 4'd7 || V !== 1'b1) $display("FAIL ovf_8m1: got D=%0d V=%b want D=7 V=1", D, V);
    else pass_cnt++;
    start_op(4'd6, 4'd2, 1'b0, 1'b1, 1'b1);
    wait_done(cyc, nb);
    total_cnt++;
    if (D !== 4'd4 || V !== 1'b0) $display("FAIL ovf_6m2: got D=%0d V=%b want D=4 V=0", D, V);
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bi = 1'b0; sa = 1'b1; sb = 1'b1;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_vectors();
    test_start_ignored();
    test_input_change();
    test_mid_reset();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
